// File: rtl/bicubic_inner_product_pipe_pkg.sv
// bicubic_inner_product_pipe_pkg: default parameters and sum-width helper
package bicubic_inner_product_pipe_pkg;
    localparam int NTAP_D  = 4;
    localparam int WW_D    = 4;
    localparam int PW_D    = 9;
    localparam int OW_D    = 8;
    localparam int SHIFT_D = 3;

    function automatic int sum_width(input int ow, input int ntap);
        return ow + $clog2(ntap) + 2;
    endfunction
endpackage

// File: rtl/bicubic_tap_mult.sv
// bicubic_tap_mult: sign-magnitude weight x pixel, shifted, as two's complement
module bicubic_tap_mult #(
    parameter int WW    = 4,
    parameter int PW    = 9,
    parameter int SHIFT = 3,
    parameter int SW    = 12
) (
    input  logic [WW-1:0] weight,
    input  logic [PW-1:0] pixel,
    output logic [SW-1:0] prod
);
    localparam int MW = WW + PW - 2;
    logic [MW-1:0] full;
    logic [MW-1:0] mag;
    logic [SW-1:0] ext;
    logic          neg;

    always_comb begin
        full = weight[WW-2:0] * pixel[PW-2:0];
        mag  = full >> SHIFT;
        ext  = SW'(mag);
        // a product truncated to zero must never come out negative
        neg  = (weight[WW-1] ^ pixel[PW-1]) && (mag != '0);
        prod = neg ? -ext : ext;
    end
endmodule

// File: rtl/bicubic_inner_product_pipe.sv
// bicubic_inner_product_pipe: 3-stage sign-magnitude inner product with
// saturation, optional negative clipping and a saturation counter
module bicubic_inner_product_pipe
    import bicubic_inner_product_pipe_pkg::*;
#(
    parameter int NTAP  = NTAP_D,
    parameter int WW    = WW_D,
    parameter int PW    = PW_D,
    parameter int OW    = OW_D,
    parameter int SHIFT = SHIFT_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NTAP*WW-1:0] weights,
    input  logic [NTAP*PW-1:0] pixels,
    input  logic               clip_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW-1:0]      out_mag,
    output logic               out_sign,
    output logic               out_sat,
    output logic [15:0]        sat_count,
    input  logic               sat_clr
);
    localparam int SW = sum_width(OW, NTAP);
    localparam logic [SW-1:0] MAXV = SW'((1 << OW) - 1);

    logic          advance;
    logic          v1, v2;
    logic [SW-1:0] prod_c [NTAP];
    logic [SW-1:0] prod1  [NTAP];
    logic          clip1, clip2;
    logic [SW-1:0] sum_c, sum2, abs_c;
    logic          neg_c, ovf_c, kill_c;
    logic [OW-1:0] mag_c;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar i = 0; i < NTAP; i++) begin : g_tap
        bicubic_tap_mult #(.WW(WW), .PW(PW), .SHIFT(SHIFT), .SW(SW)) u_tap (
            .weight(weights[i*WW +: WW]),
            .pixel (pixels[i*PW +: PW]),
            .prod  (prod_c[i])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NTAP; i++)
            sum_c = sum_c + prod1[i];
    end

    always_comb begin
        neg_c  = sum2[SW-1];
        abs_c  = neg_c ? -sum2 : sum2;
        ovf_c  = abs_c > MAXV;
        kill_c = clip2 & neg_c;
        mag_c  = kill_c ? '0 : (ovf_c ? '1 : abs_c[OW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < NTAP; i++)
                prod1[i] <= prod_c[i];
            clip1 <= clip_en;
            sum2  <= sum_c;
            clip2 <= clip1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_sign  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            out_mag   <= mag_c;
            out_sign  <= neg_c & ~kill_c;
            out_sat   <= ovf_c & ~kill_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
endmodule

// File: tb/tb_bicubic_inner_product_pipe.sv
// tb_bicubic_inner_product_pipe: directed vector table plus stall, reset
// and counter-clear sequences for the inner product pipeline
module tb_bicubic_inner_product_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] weights = '0;
    logic [35:0] pixels = '0;
    logic        clip_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_mag;
    logic        out_sign;
    logic        out_sat;
    logic [15:0] sat_count;
    logic        sat_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [15:0] w;
        logic [35:0] p;
        logic        clip;
        logic [7:0]  mag;
        logic        sign;
        logic        sat;
    } vec_t;

    vec_t vecs[12];

    bicubic_inner_product_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .weights(weights), .pixels(pixels), .clip_en(clip_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
        .out_sign(out_sign), .out_sat(out_sat), .sat_count(sat_count),
        .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wt(input logic [3:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [35:0] px(input logic [8:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_beat(input vec_t v, input logic clr);
        int n;
        @(negedge clk);
        weights = v.w; pixels = v.p; clip_en = v.clip; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 3);
        chk("out_mag", int'(out_mag), int'(v.mag));
        chk("out_sign", int'(out_sign), int'(v.sign));
        chk("out_sat", int'(out_sat), int'(v.sat));
        sat_clr = clr;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        if (clr) exp_cnt = 0;
        else if (v.sat && exp_cnt != 16'hFFFF) exp_cnt++;
        chk("sat_count", int'(sat_count), exp_cnt);
        chk("out_valid_drop", int'(out_valid), 0);
    endtask

    initial begin
        int sent, recv, seen;
        logic acc, was_stalled;
        logic [7:0] held;

        vecs[0]  = '{wt(4'hB, 4'h6, 4'h4, 4'h9), px(255, 255, 255, 248), 1'b0, 8'd192, 1'b0, 1'b0};
        vecs[1]  = '{wt(4'h7, 4'h7, 4'h7, 4'h7), px(255, 255, 255, 255), 1'b0, 8'd255, 1'b0, 1'b1};
        vecs[2]  = '{wt(4'h9, 4'h9, 4'h9, 4'h9), px(100, 100, 100, 100), 1'b0, 8'd48,  1'b1, 1'b0};
        vecs[3]  = '{wt(4'h9, 4'h9, 4'h9, 4'h9), px(100, 100, 100, 100), 1'b1, 8'd0,   1'b0, 1'b0};
        vecs[4]  = '{wt(4'h8, 4'h8, 4'h8, 4'h8), px(255, 255, 255, 255), 1'b0, 8'd0,   1'b0, 1'b0};
        vecs[5]  = '{wt(4'h7, 4'h2, 4'h0, 4'h0), px(255, 128, 0, 0),     1'b0, 8'd255, 1'b0, 1'b0};
        vecs[6]  = '{wt(4'h7, 4'h2, 4'h0, 4'h0), px(255, 132, 0, 0),     1'b0, 8'd255, 1'b0, 1'b1};
        vecs[7]  = '{wt(4'hF, 4'hF, 4'hF, 4'hF), px(255, 255, 255, 255), 1'b0, 8'd255, 1'b1, 1'b1};
        vecs[8]  = '{wt(4'hF, 4'hF, 4'hF, 4'hF), px(255, 255, 255, 255), 1'b1, 8'd0,   1'b0, 1'b0};
        vecs[9]  = '{wt(4'h4, 4'h4, 4'h4, 4'h4), px(9'h164, 100, 9'h132, 10), 1'b0, 8'd20, 1'b1, 1'b0};
        vecs[10] = '{wt(4'h9, 4'h9, 4'h9, 4'h9), px(5, 5, 5, 5),         1'b0, 8'd0,   1'b0, 1'b0};
        vecs[11] = '{wt(4'h9, 4'h1, 4'h0, 4'h0), px(100, 100, 0, 0),     1'b0, 8'd0,   1'b0, 1'b0};

        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_mag", int'(out_mag), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_sat_count", int'(sat_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_beat(vecs[i], 1'b0);

        // five beats streamed, consumer stalls for four cycles
        sent = 0; recv = 0; was_stalled = 1'b0; held = '0;
        weights = 16'h0001; clip_en = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            in_valid = (sent < 5);
            pixels = px(9'(8 * (sent + 1)), 0, 0, 0);
            out_ready = !(c >= 4 && c < 8);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (was_stalled) chk("stall_hold", int'(out_mag), int'(held));
                if (out_ready) begin
                    chk("stream_mag", int'(out_mag), recv + 1);
                    recv++;
                    was_stalled = 1'b0;
                end else begin
                    chk("stall_in_ready", int'(in_ready), 0);
                    held = out_mag;
                    was_stalled = 1'b1;
                end
            end
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_sent", sent, 5);
        chk("stream_recv", recv, 5);

        // reset with three beats in flight
        @(negedge clk);
        weights = vecs[1].w; pixels = vecs[1].p; clip_en = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_mag", int'(out_mag), 0);
        chk("midrst_out_sat", int'(out_sat), 0);
        chk("midrst_sat_count", int'(sat_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("stale_after_rst", seen, 0);
        run_beat(vecs[0], 1'b0);

        // clear coincident with a saturated handshake
        run_beat(vecs[1], 1'b0);
        run_beat(vecs[1], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d, expected %0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
